// File: rtl/mod6_phase_tracker_if.sv
// mod6_phase_tracker_if
// Bundles the sample inputs and the decoded/status outputs of the mod-6
// phase tracker. Clock and reset stay outside as plain module ports.
//   en, Qa, Qb, Qc : sample enable and counter state bits (master -> slave)
//   phase_idx, phase_onehot, valid, locked, wrap, err_illegal, err_seq,
//   cycle_count, err_count : tracker results (slave -> master)
interface mod6_phase_tracker_if #(
  parameter int CYC_W = 16,
  parameter int ERR_W = 8
);
  logic             en;
  logic             Qa;
  logic             Qb;
  logic             Qc;
  logic [2:0]       phase_idx;
  logic [5:0]       phase_onehot;
  logic             valid;
  logic             locked;
  logic             wrap;
  logic             err_illegal;
  logic             err_seq;
  logic [CYC_W-1:0] cycle_count;
  logic [ERR_W-1:0] err_count;

  modport master (
    output en, Qa, Qb, Qc,
    input  phase_idx, phase_onehot, valid, locked, wrap,
           err_illegal, err_seq, cycle_count, err_count
  );

  modport slave (
    input  en, Qa, Qb, Qc,
    output phase_idx, phase_onehot, valid, locked, wrap,
           err_illegal, err_seq, cycle_count, err_count
  );
endinterface

// File: rtl/mod6_phase_tracker.sv
// mod6_phase_tracker
// Samples the JK mod-6 counter state {Qa,Qb,Qc}, decodes it to a phase index
// and one-hot phase, checks each transition against the legal sequence,
// acquires/holds lock, counts completed cycles and flags errors.
//   clk  : rising-edge clock shared with the counter
//   rst  : asynchronous active-high reset
//   trk  : slave side of mod6_phase_tracker_if (inputs en/Qa/Qb/Qc,
//          all registered outputs)
//
// state  | meaning
// SEARCH | no reference phase yet; next legal code is accepted unchecked
// ACQ    | tracking, counting consecutive correct transitions toward lock
// LOCKED | LOCK_COUNT correct transitions seen; cycles are counted
module mod6_phase_tracker #(
  parameter int LOCK_COUNT = 6,
  parameter int CYC_W      = 16,
  parameter int ERR_W      = 8,
  parameter int ALLOW_HOLD = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  mod6_phase_tracker_if.slave      trk
);

  typedef enum logic [1:0] {SEARCH, ACQ, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t           state_q;
  logic [2:0]       prev_q;
  logic [3:0]       match_q;
  logic [2:0]       phase_idx_q;
  logic [5:0]       phase_onehot_q;
  logic             valid_q;
  logic             wrap_q;
  logic             err_illegal_q;
  logic             err_seq_q;
  logic [CYC_W-1:0] cycle_count_q;
  logic [ERR_W-1:0] err_count_q;

  logic       code_legal;
  logic [2:0] code_idx;
  logic [2:0] succ_idx;
  logic       is_succ;
  logic       is_hold;
  logic [3:0] match_inc;

  // Gray-like JK counter code map; 100 and 111 never occur in a healthy counter.
  always_comb begin
    code_legal = 1'b1;
    code_idx   = 3'd0;
    case ({trk.Qa, trk.Qb, trk.Qc})
      3'b000:  code_idx = 3'd0;
      3'b010:  code_idx = 3'd1;
      3'b011:  code_idx = 3'd2;
      3'b110:  code_idx = 3'd3;
      3'b101:  code_idx = 3'd4;
      3'b001:  code_idx = 3'd5;
      default: code_legal = 1'b0;
    endcase
  end

  assign succ_idx  = (prev_q == 3'd5) ? 3'd0 : prev_q + 3'd1;
  assign is_succ   = (code_idx == succ_idx);
  assign is_hold   = (code_idx == prev_q) && (ALLOW_HOLD != 0);
  assign match_inc = match_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= SEARCH;
      prev_q         <= 3'd0;
      match_q        <= 4'd0;
      phase_idx_q    <= 3'd0;
      phase_onehot_q <= 6'd0;
      valid_q        <= 1'b0;
      wrap_q         <= 1'b0;
      err_illegal_q  <= 1'b0;
      err_seq_q      <= 1'b0;
      cycle_count_q  <= '0;
      err_count_q    <= '0;
    end else begin
      wrap_q        <= 1'b0;
      err_illegal_q <= 1'b0;
      err_seq_q     <= 1'b0;
      if (trk.en) begin
        if (!code_legal) begin
          // phase_idx and prev phase deliberately keep their last values
          err_illegal_q  <= 1'b1;
          state_q        <= SEARCH;
          valid_q        <= 1'b0;
          phase_onehot_q <= 6'd0;
          match_q        <= 4'd0;
          if (err_count_q != '1) err_count_q <= err_count_q + ERR_W'(1);
        end else begin
          valid_q        <= 1'b1;
          phase_idx_q    <= code_idx;
          phase_onehot_q <= 6'b000001 << code_idx;
          prev_q         <= code_idx;
          if (state_q == SEARCH) begin
            state_q <= ACQ;
            match_q <= 4'd0;
          end else if (is_succ) begin
            if (state_q == ACQ) begin
              match_q <= match_inc;
              if (match_inc == LOCK_N) state_q <= LOCKED;
            end else if (match_q != LOCK_N) begin
              match_q <= match_inc;
            end
            if (prev_q == 3'd5) begin
              wrap_q <= 1'b1;
              // a wrap on the very edge that achieves lock is not a counted cycle
              if (state_q == LOCKED) cycle_count_q <= cycle_count_q + CYC_W'(1);
            end
          end else if (!is_hold) begin
            // wrong code is adopted as the new reference phase
            err_seq_q <= 1'b1;
            match_q   <= 4'd0;
            state_q   <= ACQ;
            if (err_count_q != '1) err_count_q <= err_count_q + ERR_W'(1);
          end
        end
      end
    end
  end

  assign trk.phase_idx    = phase_idx_q;
  assign trk.phase_onehot = phase_onehot_q;
  assign trk.valid        = valid_q;
  assign trk.locked       = (state_q == LOCKED);
  assign trk.wrap         = wrap_q;
  assign trk.err_illegal  = err_illegal_q;
  assign trk.err_seq      = err_seq_q;
  assign trk.cycle_count  = cycle_count_q;
  assign trk.err_count    = err_count_q;

endmodule

// File: tb/tb_mod6_phase_tracker.sv
// tb_mod6_phase_tracker
// Drives three tracker instances (default, ALLOW_HOLD=1, ERR_W=2) with the
// same counter codes. The default instance is checked against a hand-written
// vector table through a scoreboard queue; corner cases are hand sequences.
module tb_mod6_phase_tracker;

  logic clk;
  logic rst;

  mod6_phase_tracker_if #(.CYC_W(16), .ERR_W(8)) if_main ();
  mod6_phase_tracker_if #(.CYC_W(16), .ERR_W(8)) if_hold ();
  mod6_phase_tracker_if #(.CYC_W(16), .ERR_W(2)) if_sat ();

  mod6_phase_tracker #(.LOCK_COUNT(6), .CYC_W(16), .ERR_W(8), .ALLOW_HOLD(0))
    u_main (.clk(clk), .rst(rst), .trk(if_main));
  mod6_phase_tracker #(.LOCK_COUNT(6), .CYC_W(16), .ERR_W(8), .ALLOW_HOLD(1))
    u_hold (.clk(clk), .rst(rst), .trk(if_hold));
  mod6_phase_tracker #(.LOCK_COUNT(6), .CYC_W(16), .ERR_W(2), .ALLOW_HOLD(0))
    u_sat (.clk(clk), .rst(rst), .trk(if_sat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [2:0]  code;
    logic [2:0]  ph;
    logic        v;
    logic        l;
    logic        w;
    logic        ei;
    logic        es;
    logic [15:0] cyc;
    logic [7:0]  errc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [2:0] pc(input int p);
    case (p)
      0: return 3'b000;
      1: return 3'b010;
      2: return 3'b011;
      3: return 3'b110;
      4: return 3'b101;
      default: return 3'b001;
    endcase
  endfunction

  task automatic add(input logic e, input logic [2:0] c, input int ph,
                     input logic v, input logic l, input logic w,
                     input logic ei, input logic es, input int cyc, input int errc);
    vec_t r;
    r.en = e; r.code = c; r.ph = 3'(ph); r.v = v; r.l = l; r.w = w;
    r.ei = ei; r.es = es; r.cyc = 16'(cyc); r.errc = 8'(errc);
    vecs.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_main(input vec_t e, input string tag);
    logic [5:0] oh;
    oh = e.v ? (6'b000001 << e.ph) : 6'b000000;
    chk({tag, " phase_idx"},    32'(if_main.phase_idx),    32'(e.ph));
    chk({tag, " phase_onehot"}, 32'(if_main.phase_onehot), 32'(oh));
    chk({tag, " valid"},        32'(if_main.valid),        32'(e.v));
    chk({tag, " locked"},       32'(if_main.locked),       32'(e.l));
    chk({tag, " wrap"},         32'(if_main.wrap),         32'(e.w));
    chk({tag, " err_illegal"},  32'(if_main.err_illegal),  32'(e.ei));
    chk({tag, " err_seq"},      32'(if_main.err_seq),      32'(e.es));
    chk({tag, " cycle_count"},  32'(if_main.cycle_count),  32'(e.cyc));
    chk({tag, " err_count"},    32'(if_main.err_count),    32'(e.errc));
  endtask

  task automatic set_in(input logic e, input logic [2:0] c);
    if_main.en = e; {if_main.Qa, if_main.Qb, if_main.Qc} = c;
    if_hold.en = e; {if_hold.Qa, if_hold.Qb, if_hold.Qc} = c;
    if_sat.en  = e; {if_sat.Qa,  if_sat.Qb,  if_sat.Qc}  = c;
  endtask

  task automatic step(input logic e, input logic [2:0] c);
    @(negedge clk);
    set_in(e, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(1'b0, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t zero_v;
  vec_t exp_v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_v = '{en: 1'b0, code: 3'b000, ph: 3'd0, v: 1'b0, l: 1'b0, w: 1'b0,
               ei: 1'b0, es: 1'b0, cyc: 16'd0, errc: 8'd0};

    // acquisition from 000, lock on edge 7 (which is also an unlocked wrap)
    add(1, pc(0), 0, 1, 0, 0, 0, 0, 0, 0);
    for (int p = 1; p < 6; p++) add(1, pc(p), p, 1, 0, 0, 0, 0, 0, 0);
    add(1, pc(0), 0, 1, 1, 1, 0, 0, 0, 0);
    // three full locked cycles
    for (int c = 1; c <= 3; c++) begin
      for (int p = 1; p < 6; p++) add(1, pc(p), p, 1, 1, 0, 0, 0, c - 1, 0);
      add(1, pc(0), 0, 1, 1, 1, 0, 0, c, 0);
    end
    // en=0 with changing inputs: hold everything, pulses cleared
    add(0, pc(3),  0, 1, 1, 0, 0, 0, 3, 0);
    add(0, 3'b111, 0, 1, 1, 0, 0, 0, 3, 0);
    add(1, pc(1),  1, 1, 1, 0, 0, 0, 3, 0);
    // illegal while locked, then relock after LOCK_COUNT+1 edges
    add(1, 3'b111, 1, 0, 0, 0, 1, 0, 3, 1);
    add(1, pc(2),  2, 1, 0, 0, 0, 0, 3, 1);
    add(1, pc(3),  3, 1, 0, 0, 0, 0, 3, 1);
    add(1, pc(4),  4, 1, 0, 0, 0, 0, 3, 1);
    add(1, pc(5),  5, 1, 0, 0, 0, 0, 3, 1);
    add(1, pc(0),  0, 1, 0, 1, 0, 0, 3, 1);
    add(1, pc(1),  1, 1, 0, 0, 0, 0, 3, 1);
    add(1, pc(2),  2, 1, 1, 0, 0, 0, 3, 1);
    // sequence skips 2->1 and 1->3
    add(1, pc(1),  1, 1, 0, 0, 0, 1, 3, 2);
    add(1, pc(3),  3, 1, 0, 0, 0, 1, 3, 3);
    // repeated codes are errors with ALLOW_HOLD=0
    add(1, pc(3),  3, 1, 0, 0, 0, 1, 3, 4);
    add(1, pc(2),  2, 1, 0, 0, 0, 1, 3, 5);
    add(1, pc(2),  2, 1, 0, 0, 0, 1, 3, 6);
    // illegal 100: phase_idx holds
    add(1, 3'b100, 2, 0, 0, 0, 1, 0, 3, 7);

    rst = 1'b1;
    set_in(1'b0, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_main(zero_v, "reset");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      set_in(vecs[i].en, vecs[i].code);
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard empty", 32'd1, 32'd0);
      end else begin
        exp_v = sb.pop_front();
        check_main(exp_v, $sformatf("vec%0d", i));
      end
    end
    chk("sat err_count after table", 32'(if_sat.err_count), 32'd3);

    // relock, then asynchronous reset mid-cycle
    step(1, pc(0));
    for (int p = 1; p < 6; p++) step(1, pc(p));
    step(1, pc(0));
    chk("relock locked", 32'(if_main.locked), 32'd1);
    chk("relock cycle_count", 32'(if_main.cycle_count), 32'd3);
    @(negedge clk);
    set_in(1'b1, pc(1));
    @(posedge clk);
    #2;
    set_in(1'b1, pc(3));
    rst = 1'b1;
    #1;
    check_main(zero_v, "async_rst");
    @(posedge clk);
    #1;
    check_main(zero_v, "rst_held");
    @(negedge clk);
    set_in(1'b0, pc(3));
    rst = 1'b0;
    #1;
    check_main(zero_v, "rst_released");

    // repeated code: ALLOW_HOLD=0 errors, ALLOW_HOLD=1 keeps match unchanged
    step(1, pc(0));
    step(1, pc(1));
    step(1, pc(2));
    step(1, pc(2));
    chk("hold0 err_seq", 32'(if_main.err_seq), 32'd1);
    chk("hold0 err_count", 32'(if_main.err_count), 32'd1);
    chk("hold1 err_seq", 32'(if_hold.err_seq), 32'd0);
    chk("hold1 err_count", 32'(if_hold.err_count), 32'd0);
    chk("hold1 phase_idx", 32'(if_hold.phase_idx), 32'd2);
    step(1, pc(3));
    step(1, pc(4));
    step(1, pc(5));
    chk("hold1 not yet locked", 32'(if_hold.locked), 32'd0);
    step(1, pc(0));
    chk("hold1 locked", 32'(if_hold.locked), 32'd1);
    chk("hold1 wrap", 32'(if_hold.wrap), 32'd1);
    chk("hold0 not locked", 32'(if_main.locked), 32'd0);

    // err_count saturation with ERR_W=2
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(1, 3'b111);
      chk($sformatf("sat err_count %0d", k), 32'(if_sat.err_count), (k < 3) ? 32'(k) : 32'd3);
      chk($sformatf("sat err_illegal %0d", k), 32'(if_main.err_illegal), 32'd1);
      chk($sformatf("sat err_seq %0d", k), 32'(if_main.err_seq), 32'd0);
    end
    chk("main err_count after 5", 32'(if_main.err_count), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mod6_phase_tracker.md
Name: mod6_phase_tracker

Overview:
Consumer end of the JK-flip-flop mod-6 counter. Samples the counter's three state bits {Qa,Qb,Qc} and decodes them into a phase index and a one-hot phase. Checks every transition against the legal sequence, acquires and holds lock, counts completed cycles, and flags illegal codes and sequence breaks. Sits beside the counter in the same clock domain and feeds downstream phase-sequenced logic.

Parameters:
LOCK_COUNT, 6, consecutive correct transitions needed to assert locked (1..15)
CYC_W, 16, width of cycle_count (wraps modulo 2^CYC_W)
ERR_W, 8, width of err_count (saturating)
ALLOW_HOLD, 0, 1 = a repeated code is tolerated; 0 = a repeated code is a sequence error

Ports:
clk  in  1  rising-edge clock, same clock as the counter
rst  in  1  asynchronous active-high reset
en  in  1  sample enable; 0 = ignore inputs and hold all registered state
Qa  in  1  counter state bit A
Qb  in  1  counter state bit B
Qc  in  1  counter state bit C
phase_idx  out  3  decoded phase 0..5
phase_onehot  out  6  bit[phase_idx] set when valid, else 0
valid  out  1  last sampled code was legal
locked  out  1  tracker is locked to the sequence
wrap  out  1  one-cycle pulse on a correct 5->0 transition
err_illegal  out  1  one-cycle pulse on an illegal code
err_seq  out  1  one-cycle pulse on a legal code that is not the expected successor
cycle_count  out  CYC_W  completed cycles while locked
err_count  out  ERR_W  total err_illegal plus err_seq events, saturating at all-ones

Behaviour:
- Code map, written {Qa,Qb,Qc}:
  - 000 -> 0, 010 -> 1, 011 -> 2, 110 -> 3, 101 -> 4, 001 -> 5.
  - Successor of phase p is (p+1) mod 6.
  - Codes 100 and 111 are illegal.
- Sampling:
  - Values are sampled at each rising clk with en=1.
  - All outputs are registered and update at that same edge.
  - Outputs therefore lag the counter's own state by one clock.
- Reset (asynchronous, any time, including mid-lock):
  - state=SEARCH.
  - All outputs 0: phase_idx=0, phase_onehot=0, valid=0, locked=0, all pulses 0, cycle_count=0, err_count=0.
  - Internal previous-phase register and match counter cleared.
- en=0: all state and counters hold; wrap, err_illegal and err_seq are driven 0.
- FSM states: SEARCH, ACQ, LOCKED. locked=1 only in LOCKED.
- Illegal code (any state):
  - err_illegal=1.
  - Next state SEARCH; valid=0; phase_onehot=0; phase_idx holds its last value.
  - Match counter cleared.
- SEARCH + legal code: valid=1, decode the code, go to ACQ with match=0. No error is possible in this state.
- ACQ or LOCKED + legal code, compared with the previous phase:
  - Expected successor:
    - match increments.
    - In ACQ, when match+1 == LOCK_COUNT, go to LOCKED.
    - In LOCKED, match saturates.
  - Same code, ALLOW_HOLD=1: accepted. No match change, no error, no wrap.
  - Same code, ALLOW_HOLD=0: treated as a wrong code (next bullet).
  - Wrong code: err_seq=1, match cleared, next state ACQ, new code accepted as the current phase.
- Previous phase updates on every legal sample.
- wrap=1 on a correct 5->0 transition in ACQ or LOCKED.
- cycle_count increments on a wrap only when the state before the edge is LOCKED.
- err_count increments by 1 on each err_illegal or err_seq event and saturates.
- At most one of err_illegal and err_seq is asserted per edge.

Test Plan:
- Reset values: assert rst mid-run with the tracker locked -> every output is 0 immediately (asynchronous) and stays 0 until the first sample after release.
- Lock acquisition: LOCK_COUNT=6, free-running counter starting at 000 -> valid=1 after edge 1; locked=1 after edge 7.
- Wrap counting: counter runs 3 full cycles after lock -> wrap pulses exactly at each 5->0 transition; cycle_count=3.
- Illegal code: force {Qa,Qb,Qc}=111 for one sample while locked -> err_illegal pulse, valid=0, locked=0, err_count=1, phase_onehot=0. After release the tracker relocks after LOCK_COUNT+1 further edges.
- Sequence skip: drive 010 then 110 -> err_seq pulse, state ACQ, phase_idx=3.
- Hold, ALLOW_HOLD=0: repeat 011 -> err_seq pulse. Same stimulus with ALLOW_HOLD=1 -> no error and no change to match.
- err_count saturation: ERR_W=2, inject 5 errors -> err_count stops at 3.
- en=0: hold en=0 while the inputs change -> no output changes and no pulses.
